// File: rtl/ysyx_210247_pipe_ctrl_pkg.sv
// Shared types and widths for the central pipeline controller.
// Optional perf counters are built under YSYX_210247_PIPE_PERF_EN.
package ysyx_210247_pipe_ctrl_pkg;

   localparam int PC_ADDR_W = 64;
   localparam int PERF_W    = 64;

   typedef enum logic [1:0] {
      PC_RUN     = 2'd0,
      PC_DRAIN   = 2'd1,
      PC_DISCARD = 2'd2
   } pc_state_e;

endpackage

// File: rtl/ysyx_210247_pipe_ctrl_if.sv
// Stage status in, back-pressure / flush / redirect out.
// master = pipeline stages, slave = controller.
interface ysyx_210247_pipe_ctrl_if
   import ysyx_210247_pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W = PC_ADDR_W
) ();

   logic              id_valid;
   logic              ex_valid;
   logic              mem_valid;
   logic              wb_valid;
   logic              id_ready_go;
   logic              ex_ready_go;
   logic              mem_ready_go;
   logic              wb_ready_go;
   logic              id_hazard;
   logic              ex_redirect;
   logic [ADDR_W-1:0] ex_redirect_pc;
   logic              wb_trap;
   logic [ADDR_W-1:0] wb_trap_pc;
   logic              if_busy;
   logic              mem_busy;
   logic              id_allow_in;
   logic              ex_allow_in;
   logic              mem_allow_in;
   logic              wb_allow_in;
   logic              flush_if_id;
   logic              flush_id_ex;
   logic              flush_ex_mem;
   logic              flush_mem_wb;
   logic              pc_redirect;
   logic [ADDR_W-1:0] pc_redirect_target;
   logic              if_discard;

   modport master (
      output id_valid, ex_valid, mem_valid, wb_valid,
      output id_ready_go, ex_ready_go,
      output mem_ready_go, wb_ready_go,
      output id_hazard, ex_redirect, ex_redirect_pc,
      output wb_trap, wb_trap_pc, if_busy, mem_busy,
      input  id_allow_in, ex_allow_in,
      input  mem_allow_in, wb_allow_in,
      input  flush_if_id, flush_id_ex,
      input  flush_ex_mem, flush_mem_wb,
      input  pc_redirect, pc_redirect_target, if_discard
   );

   modport slave (
      input  id_valid, ex_valid, mem_valid, wb_valid,
      input  id_ready_go, ex_ready_go,
      input  mem_ready_go, wb_ready_go,
      input  id_hazard, ex_redirect, ex_redirect_pc,
      input  wb_trap, wb_trap_pc, if_busy, mem_busy,
      output id_allow_in, ex_allow_in,
      output mem_allow_in, wb_allow_in,
      output flush_if_id, flush_id_ex,
      output flush_ex_mem, flush_mem_wb,
      output pc_redirect, pc_redirect_target, if_discard
   );

endinterface

// File: rtl/ysyx_210247_pipe_perf.sv
// Stall / flush event counters, wrapping modulo 2^PERF_W.
module ysyx_210247_pipe_perf
   import ysyx_210247_pipe_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_inc,
   input  logic              flush_inc,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt
                    + {{(PERF_W-1){1'b0}}, stall_inc};
         flush_cnt <= flush_cnt
                    + {{(PERF_W-1){1'b0}}, flush_inc};
      end
   end

endmodule

// File: rtl/ysyx_210247_pipe_ctrl.sv
// Pipeline allow_in chain, flush/redirect sequencing, drain/discard FSM.
// Define YSYX_210247_PIPE_PERF_EN to build the perf counters.
module ysyx_210247_pipe_ctrl
   import ysyx_210247_pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W = PC_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   ysyx_210247_pipe_ctrl_if.slave bus,
   output logic [PERF_W-1:0]     perf_stall_cnt,
   output logic [PERF_W-1:0]     perf_flush_cnt
);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] trap_pc_q, trap_pc_d;
   logic [ADDR_W-1:0] tgt;
   logic              flush_all, flush_fe;
   logic              trap_v, redir_v, drain;

   assign trap_v  = bus.wb_valid && bus.wb_trap;
   assign redir_v = bus.ex_valid && bus.ex_ready_go
                 && bus.ex_redirect;
   assign drain   = (state_q == PC_DRAIN);

   assign bus.wb_allow_in  = !bus.wb_valid || bus.wb_ready_go;
   assign bus.mem_allow_in = !drain && (!bus.mem_valid
      || (bus.mem_ready_go && bus.wb_allow_in));
   assign bus.ex_allow_in  = !drain && (!bus.ex_valid
      || (bus.ex_ready_go && bus.mem_allow_in));
   assign bus.id_allow_in  = !drain && (!bus.id_valid
      || (bus.id_ready_go && !bus.id_hazard
          && bus.ex_allow_in));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= PC_RUN;
         trap_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         trap_pc_q <= trap_pc_d;
      end
   end

   // Outputs are gated by rst so nothing pulses while resetting.
   always_comb begin
      state_d   = state_q;
      trap_pc_d = trap_pc_q;
      flush_all = 1'b0;
      flush_fe  = 1'b0;
      tgt       = '0;
      if (!rst) begin
         unique case (state_q)
            PC_DRAIN: begin
               if (!bus.mem_busy) begin
                  flush_all = 1'b1;
                  tgt       = trap_pc_q;
                  state_d   = bus.if_busy ? PC_DISCARD
                                          : PC_RUN;
               end
            end
            PC_RUN, PC_DISCARD: begin
               if (trap_v && bus.mem_busy) begin
                  trap_pc_d = bus.wb_trap_pc;
                  state_d   = PC_DRAIN;
               end else if (trap_v) begin
                  flush_all = 1'b1;
                  tgt       = bus.wb_trap_pc;
                  state_d   = bus.if_busy ? PC_DISCARD
                                          : PC_RUN;
               end else if (state_q == PC_RUN && redir_v) begin
                  flush_fe  = 1'b1;
                  tgt       = bus.ex_redirect_pc;
                  state_d   = bus.if_busy ? PC_DISCARD
                                          : PC_RUN;
               end else if (!bus.if_busy) begin
                  state_d   = PC_RUN;
               end
            end
            default: state_d = PC_RUN;
         endcase
      end
   end

   assign bus.flush_if_id        = flush_all || flush_fe;
   assign bus.flush_id_ex        = flush_all || flush_fe;
   assign bus.flush_ex_mem       = flush_all;
   assign bus.flush_mem_wb       = flush_all;
   assign bus.pc_redirect        = flush_all || flush_fe;
   assign bus.pc_redirect_target = tgt;
   assign bus.if_discard = !rst && (state_q == PC_DISCARD);

`ifdef YSYX_210247_PIPE_PERF_EN
   ysyx_210247_pipe_perf u_perf (
      .clk       (clk),
      .rst       (rst),
      .stall_inc ((bus.id_valid && !bus.id_allow_in) || drain),
      .flush_inc (bus.pc_redirect),
      .stall_cnt (perf_stall_cnt),
      .flush_cnt (perf_flush_cnt)
   );
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule
